// File: rtl/niosduino_core_pio_poller.sv
// Periodic poller for a Nios-style input PIO with change detection.
//
// A small FSM reads the PIO data register every PERIOD+3 cycles while
// enabled, keeps the last captured word in SAMPLE, and accumulates masked
// bit changes between consecutive captures in EDGE (write-1-to-clear).
// irq is raised while IRQ_EN is set and any EDGE bit is pending.
//
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   s_address       - CSR word address (0 CTRL, 1 PERIOD, 2 MASK, 3 SAMPLE, 4 EDGE)
//   s_write         - CSR write strobe
//   s_writedata     - CSR write data
//   s_readdata      - registered CSR read data (1-cycle latency, no strobe)
//   m_address       - PIO address, always 0
//   m_read          - PIO read strobe (one cycle per poll)
//   m_readdata      - PIO read data, valid the cycle after m_read
//   irq             - change-detect interrupt
module niosduino_core_pio_poller #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        s_address,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  output logic [DATA_W-1:0] s_readdata,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CAPTURE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] edge_bits_q, edge_bits_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] edge_set;
  logic              wr_ctrl, wr_period, wr_mask, wr_edge;
  logic              en;

  assign en        = ctrl_q[0];
  assign wr_ctrl   = s_write && (s_address == 3'd0);
  assign wr_period = s_write && (s_address == 3'd1);
  assign wr_mask   = s_write && (s_address == 3'd2);
  assign wr_edge   = s_write && (s_address == 3'd4);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (en) state_d = S_WAIT;
      S_WAIT: begin
        if (!en)               state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_READ;
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = en ? S_WAIT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; irq is a function of registers only
  always_comb begin
    m_read    = (state_q == S_READ);
    m_address = '0;
    irq       = ctrl_q[1] && (|edge_bits_q);
  end

  // Datapath and CSR next-state
  always_comb begin
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    sample_d = sample_q;
    edge_set = '0;

    case (state_q)
      S_IDLE: begin
        if (en) cnt_d = period_q;
      end
      S_WAIT: begin
        if (!en)               valid_d = 1'b0;
        else if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CAPTURE: begin
        sample_d = m_readdata;
        // The first capture after enable has no prior reference word
        if (valid_q) edge_set = (m_readdata ^ sample_q) & mask_q;
        if (en) begin
          cnt_d   = period_q;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    ctrl_d   = wr_ctrl   ? s_writedata[1:0]       : ctrl_q;
    period_d = wr_period ? s_writedata[CNT_W-1:0] : period_q;
    mask_d   = wr_mask   ? s_writedata            : mask_q;

    // A newly detected change wins over a coincident clear of the same bit
    edge_bits_d = (edge_bits_q & ~(wr_edge ? s_writedata : '0)) | edge_set;

    rdata_d = '0;
    case (s_address)
      3'd0:    rdata_d[1:0]       = ctrl_q;
      3'd1:    rdata_d[CNT_W-1:0] = period_q;
      3'd2:    rdata_d            = mask_q;
      3'd3:    rdata_d            = sample_q;
      3'd4:    rdata_d            = edge_bits_q;
      default: rdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      ctrl_q      <= '0;
      period_q    <= '0;
      mask_q      <= '1;
      sample_q    <= '0;
      edge_bits_q <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      mask_q      <= mask_d;
      sample_q    <= sample_d;
      edge_bits_q <= edge_bits_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
    end
  end

  assign s_readdata = rdata_q;

endmodule

// File: tb/tb_niosduino_core_pio_poller.sv
module tb_niosduino_core_pio_poller;

  logic        clk;
  logic        reset_n;
  logic [2:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] pio;
  logic        irq;

  int total = 0;
  int bad   = 0;

  niosduino_core_pio_poller #(.DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_address  (s_address),
    .s_write    (s_write),
    .s_writedata(s_writedata),
    .s_readdata (s_readdata),
    .m_address  (m_address),
    .m_read     (m_read),
    .m_readdata (pio),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph = cycles until the next PIO read: -1 idle, -2 capture cycle, 0 read now.
  int          ph;
  logic [1:0]  mc;
  logic [15:0] mp;
  logic [31:0] mm, ms, me, mrd;
  logic        mv;

  task automatic model_reset();
    ph = -1; mc = '0; mp = '0; mm = '1; ms = '0; me = '0; mv = 1'b0; mrd = '0;
  endtask

  task automatic model_step();
    logic [31:0] rd, set, w1c, ns;
    int          nph;
    logic        nv;
    case (s_address)
      3'd0:    rd = {30'b0, mc};
      3'd1:    rd = {16'b0, mp};
      3'd2:    rd = mm;
      3'd3:    rd = ms;
      3'd4:    rd = me;
      default: rd = '0;
    endcase
    set = '0; ns = ms; nv = mv; nph = ph;
    w1c = (s_write && s_address == 3'd4) ? s_writedata : '0;
    if (ph == -2) begin
      if (mv) set = (pio ^ ms) & mm;
      ns = pio;
      if (mc[0]) begin nph = int'(mp) + 1; nv = 1'b1; end
      else begin nph = -1; nv = 1'b0; end
    end else if (ph == 0) begin
      nph = -2;
    end else if (ph > 0) begin
      if (!mc[0]) begin nph = -1; nv = 1'b0; end
      else nph = ph - 1;
    end else if (mc[0]) begin
      nph = int'(mp) + 1;
    end
    me = (me & ~w1c) | set;
    ms = ns; mv = nv; ph = nph; mrd = rd;
    if (s_write) begin
      case (s_address)
        3'd0:    mc = s_writedata[1:0];
        3'd1:    mp = s_writedata[15:0];
        3'd2:    mm = s_writedata;
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        chk("rst_m_read", {31'b0, m_read}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_rdata", s_readdata, 32'd0);
      end else begin
        chk("m_read", {31'b0, m_read}, {31'b0, (ph == 0)});
        chk("rdata", s_readdata, mrd);
        chk("irq", {31'b0, irq}, {31'b0, (mc[1] && (|me))});
        chk("m_address", {30'b0, m_address}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] v);
    s_address = a; s_writedata = v; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] v);
    s_address = a;
    @(negedge clk);
    v = s_readdata;
  endtask

  task automatic wait_mread(input int budget);
    int n;
    n = 0;
    while (m_read !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("m_read_seen", {31'b0, m_read}, 32'd1);
  endtask

  logic [31:0] d;
  logic [31:0] rst_exp [8];
  int          n;

  initial begin
    reset_n = 1'b0; s_address = '0; s_write = 1'b0; s_writedata = '0; pio = '0;
    repeat (3) tick();
    chk("reset_rdata", s_readdata, 32'd0);
    chk("reset_m_read", {31'b0, m_read}, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    reset_n = 1'b1;
    csr_rd(3'd2, d); chk("reset_mask", d, 32'hFFFF_FFFF);
    csr_rd(3'd1, d); chk("reset_period", d, 32'd0);

    // Constant input, PERIOD=5: 8-cycle poll interval, no edges
    pio = 32'h5A5A_1234;
    csr_wr(3'd1, 32'd5);
    csr_wr(3'd0, 32'd1);
    wait_mread(20);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin tick(); n++; end while (m_read !== 1'b1 && n < 20);
      chk("poll_interval", n, 32'd8);
    end
    repeat (3) tick();
    csr_rd(3'd3, d); chk("sample_const", d, 32'h5A5A_1234);
    csr_rd(3'd4, d); chk("edge_const", d, 32'd0);
    chk("irq_const", {31'b0, irq}, 32'd0);

    // Change detection with MASK=1
    csr_wr(3'd0, 32'd0);
    repeat (12) tick();
    pio = 32'h0;
    csr_wr(3'd2, 32'd1);
    csr_wr(3'd0, 32'd3);
    wait_mread(20); tick(); tick();
    pio = 32'h11;
    wait_mread(20); tick();
    chk("irq_during_capture", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_after_capture", {31'b0, irq}, 32'd1);
    chk("model_edge_pin", me, 32'd1);
    csr_rd(3'd4, d); chk("edge_bit0", d, 32'd1);

    // W1C with no new change, then W1C coincident with a new set
    csr_wr(3'd4, 32'd1);
    chk("w1c_irq", {31'b0, irq}, 32'd0);
    csr_rd(3'd4, d); chk("w1c_edge", d, 32'd0);
    pio = 32'h10;
    wait_mread(20); tick();
    csr_wr(3'd4, 32'd1);
    chk("set_wins_irq", {31'b0, irq}, 32'd1);
    csr_rd(3'd4, d); chk("set_wins_edge", d, 32'd1);

    // Clear EN on the READ cycle: capture still completes
    pio = 32'h77;
    wait_mread(20);
    csr_wr(3'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_read", {31'b0, m_read}, 32'd0);
    end
    csr_rd(3'd3, d); chk("inflight_sample", d, 32'h77);
    csr_wr(3'd4, 32'hFFFF_FFFF);
    csr_wr(3'd2, 32'hFFFF_FFFF);
    pio = 32'h88;
    csr_wr(3'd0, 32'd1);
    wait_mread(20); tick(); tick();
    csr_rd(3'd4, d); chk("first_capture_no_edge", d, 32'd0);
    csr_rd(3'd3, d); chk("reenable_sample", d, 32'h88);
    chk("model_sample_pin", ms, 32'h88);

    // Unused address reads 0, SAMPLE is read-only
    csr_rd(3'd6, d); chk("addr6_zero", d, 32'd0);
    csr_wr(3'd3, 32'hDEAD_BEEF);
    csr_rd(3'd3, d); chk("sample_ro", d, 32'h88);

    // Reset during a long WAIT
    csr_wr(3'd1, 32'h0000_FFFF);
    wait_mread(20);
    repeat (20) tick();
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    rst_exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), d);
      chk($sformatf("post_reset_csr%0d", a), d, rst_exp[a]);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_reset_no_read", {31'b0, m_read}, 32'd0);
    end
    csr_wr(3'd1, 32'd2);
    csr_wr(3'd0, 32'd1);
    wait_mread(10);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      s_write   = ($urandom_range(0, 3) == 0);
      s_address = 3'($urandom_range(0, 7));
      case (s_address)
        3'd0:    s_writedata = $urandom | (($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0);
        3'd1:    s_writedata = $urandom_range(0, 6);
        default: s_writedata = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) pio = pio ^ (32'd1 << $urandom_range(0, 7));
      reset_n = !((c % 997) == 500);
      tick();
    end
    s_write = 1'b0;
    reset_n = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/niosduino_core_pio_poller.md
NIOSDUINO_CORE_PIO_POLLER -- requirements
Module: niosduino_core_pio_poller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the polled input word and of both data buses.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the poll-period counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port s_address, input, 3, the CSR slave word address.
REQ-006 SHALL have port s_write, input, 1, the CSR write strobe.
REQ-007 SHALL have port s_writedata, input, DATA_W, the CSR write data.
REQ-008 SHALL have port s_readdata, output, DATA_W, the registered CSR read data.
REQ-009 SHALL have port m_address, output, 2, the address driven to the polled input PIO; it is constant 0.
REQ-010 SHALL have port m_read, output, 1, the poll read strobe to the PIO.
REQ-011 SHALL have port m_readdata, input, DATA_W, the PIO read data, valid exactly 1 cycle after m_read.
REQ-012 SHALL have port irq, output, 1, the change-detect interrupt.

Function
REQ-013 CSR map SHALL be: 0 CTRL (bit0 EN, bit1 IRQ_EN, rw); 1 PERIOD (CNT_W LSBs, rw); 2 MASK (rw); 3 SAMPLE (ro, last captured word); 4 EDGE (read returns captured changes, write-1-to-clear).
REQ-014 s_readdata SHALL register the addressed CSR every cycle (1-cycle latency, no read strobe, no read side effects); unused bits and addresses 5-7 SHALL read 0.
REQ-015 Writes to address 3 or 5-7 SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, WAIT, READ, CAPTURE.
REQ-017 IDLE: m_read=0; when EN=1, load cnt<=PERIOD and go to WAIT.
REQ-018 WAIT: if EN=0, go to IDLE; else if cnt==0, go to READ; else decrement cnt.
REQ-019 READ: assert m_read=1 for exactly this one cycle, then go to CAPTURE unconditionally.
REQ-020 CAPTURE: SAMPLE<=m_readdata; set VALID; then if EN=1 reload cnt<=PERIOD and go to WAIT, else go to IDLE.
REQ-021 Poll interval with EN held SHALL be PERIOD+3 cycles (READ to READ); PERIOD=0 gives 3 cycles.
REQ-022 In CAPTURE with VALID=1, EDGE SHALL be updated as EDGE | ((m_readdata XOR SAMPLE) AND MASK); with VALID=0, EDGE SHALL be unchanged.
REQ-023 VALID SHALL clear when the FSM enters IDLE, so the first capture after enable never sets EDGE.
REQ-024 If an EDGE W1C write and an EDGE set occur for the same bit in the same cycle, the set SHALL win.
REQ-025 PERIOD writes SHALL take effect at the next reload only; a running count SHALL NOT be disturbed.
REQ-026 Clearing EN during READ or CAPTURE SHALL let the in-flight poll complete, including capture and edge update, before IDLE.
REQ-027 irq SHALL equal IRQ_EN AND (|EDGE), driven only from registers with no combinational path from any input.

Reset
REQ-028 While reset_n=0: FSM=IDLE, cnt=0, CTRL=0, PERIOD=0, MASK=all ones, SAMPLE=0, EDGE=0, VALID=0, s_readdata=0, m_read=0, irq=0.
REQ-029 Reset asserted mid-poll SHALL abort immediately with no m_read pulse after assertion; operation SHALL resume only from IDLE after release.

Verification
REQ-030 PERIOD=5, EN=1, m_readdata=const -> m_read pulses every 8 cycles, SAMPLE=const, EDGE stays 0, irq=0.
REQ-031 After first capture of 0x00000000, input changes to 0x00000011, MASK=0x00000001, IRQ_EN=1 -> after next CAPTURE EDGE=0x00000001 and irq=1 on the following cycle.
REQ-032 Write EDGE=0x00000001 while no new change -> EDGE=0, irq=0 one cycle later; W1C coincident with a new set of bit0 -> EDGE bit0 stays 1.
REQ-033 Clear EN on the READ cycle -> CAPTURE still updates SAMPLE, then IDLE; re-enable with a differing input -> first capture sets no EDGE bits.
REQ-034 Pulse reset_n low during WAIT with PERIOD=0xFFFF -> all CSRs read reset values, m_read stays 0 until EN is set again.
REQ-035 Read address 6 -> s_readdata=0 next cycle; write address 3 -> SAMPLE unchanged.
